// File: rtl/simd_pkg.sv
// Shared types and helpers for the lane-partitioned SIMD add/subtract unit.
// Lane mode encoding plus the lane-boundary rule used by the carry chain.
package simd_pkg;

    typedef enum logic [1:0] {
        MODE_FULL = 2'd0,
        MODE_HALF = 2'd1,
        MODE_QUAD = 2'd2,
        MODE_SEG  = 2'd3
    } mode_t;

    // True when segment seg_idx is the least-significant segment of a lane.
    function automatic logic lane_boundary(input mode_t mode, input int seg_idx, input int nseg);
        logic b;
        b = 1'b0;
        if (seg_idx == 0) begin
            b = 1'b1;
        end else begin
            case (mode)
                MODE_FULL: b = 1'b0;
                MODE_HALF: b = (seg_idx == nseg / 2);
                MODE_QUAD: b = ((seg_idx % (nseg / 4)) == 0);
                default:   b = 1'b1;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/simd_seg_add.sv
// One SEG_W-bit slice of the SIMD adder: sum, carry out, and the carry into
// the slice MSB (needed for signed overflow when this slice tops a lane).
module simd_seg_add
    import simd_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SEG_W-1:0] low;
    logic [1:0]       high;

    // Split the add below the MSB so the carry into the MSB is visible.
    assign low  = {1'b0, a[SEG_W-2:0]} + {1'b0, b[SEG_W-2:0]} + {{(SEG_W-1){1'b0}}, cin};
    assign cmsb = low[SEG_W-1];
    assign high = {1'b0, a[SEG_W-1]} + {1'b0, b[SEG_W-1]} + {1'b0, cmsb};

    assign sum  = {high[0], low[SEG_W-2:0]};
    assign cout = high[1];

endmodule

// File: rtl/simd_addsub_pipe.sv
// Two-stage pipelined SIMD add/subtract with valid/ready handshake and per-lane
// carry/overflow flags. Define SIMD_ADD_SAT_EN to add per-lane saturation.
module simd_addsub_pipe
    import simd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_a,
    input  logic [DATA_W-1:0]         in_b,
    input  logic                      in_sub,
    input  logic [1:0]                in_mode,
`ifdef SIMD_ADD_SAT_EN
    input  logic                      in_sat,
    input  logic                      in_sgn,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_sum,
    output logic [DATA_W/SEG_W-1:0]   out_cout,
    output logic [DATA_W/SEG_W-1:0]   out_ovf,
    output logic [1:0]                out_mode
);

    // NSEG must be a power of two, at least 8, with DATA_W == SEG_W*NSEG.
    localparam int NSEG = DATA_W / SEG_W;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic              s1_sub;
    mode_t             s1_mode;
`ifdef SIMD_ADD_SAT_EN
    logic              s1_sat;
    logic              s1_sgn;
`endif

    logic              s2_adv;
    logic [DATA_W-1:0] seg_sum;
    logic [NSEG-1:0]   seg_cout;
    logic [NSEG-1:0]   seg_cmsb;
    logic [NSEG-1:0]   lane_top;
    logic [NSEG-1:0]   cout_flags;
    logic [NSEG-1:0]   ovf_flags;
    logic [DATA_W-1:0] res;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // Operand B is inverted on capture so S2 only ever adds; sub feeds the lane carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sub   <= 1'b0;
            s1_mode  <= MODE_FULL;
`ifdef SIMD_ADD_SAT_EN
            s1_sat   <= 1'b0;
            s1_sgn   <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_b    <= in_sub ? ~in_b : in_b;
                s1_sub  <= in_sub;
                s1_mode <= mode_t'(in_mode);
`ifdef SIMD_ADD_SAT_EN
                s1_sat  <= in_sat;
                s1_sgn  <= in_sgn;
`endif
            end
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic cin;
        logic co;

        if (k == 0) begin : g_first
            assign cin = s1_sub;
        end else begin : g_link
            assign cin = lane_boundary(s1_mode, k, NSEG) ? s1_sub : g_seg[k-1].co;
        end

        if (k == NSEG - 1) begin : g_msb
            assign lane_top[k] = 1'b1;
        end else begin : g_inner
            assign lane_top[k] = lane_boundary(s1_mode, k + 1, NSEG);
        end

        simd_seg_add #(.SEG_W(SEG_W)) u_add (
            .a    (s1_a[k*SEG_W +: SEG_W]),
            .b    (s1_b[k*SEG_W +: SEG_W]),
            .cin  (cin),
            .sum  (seg_sum[k*SEG_W +: SEG_W]),
            .cout (co),
            .cmsb (seg_cmsb[k])
        );

        assign seg_cout[k] = co;
    end

    assign cout_flags = seg_cout & lane_top;
    assign ovf_flags  = (seg_cout ^ seg_cmsb) & lane_top;

`ifdef SIMD_ADD_SAT_EN
    logic clamp;
    logic fill;

    // Walk from the top segment down so each lane's decision, made at its top
    // segment, is applied to every lower segment of the same lane.
    always_comb begin
        res   = seg_sum;
        clamp = 1'b0;
        fill  = 1'b0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (lane_top[k]) begin
                if (s1_sgn) begin
                    clamp = seg_cout[k] ^ seg_cmsb[k];
                    fill  = ~s1_a[k*SEG_W + SEG_W - 1];
                end else begin
                    clamp = s1_sub ? ~seg_cout[k] : seg_cout[k];
                    fill  = ~s1_sub;
                end
                if (s1_sat && clamp) begin
                    res[k*SEG_W +: SEG_W] = {SEG_W{fill}};
                    if (s1_sgn) begin
                        res[k*SEG_W + SEG_W - 1] = ~fill;
                    end
                end
            end else if (s1_sat && clamp) begin
                res[k*SEG_W +: SEG_W] = {SEG_W{fill}};
            end
        end
    end
`else
    assign res = seg_sum;
`endif

    // Output registers only move when downstream can take data, so a stalled result holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= '0;
            out_ovf   <= '0;
            out_mode  <= 2'd0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= res;
                out_cout <= cout_flags;
                out_ovf  <= ovf_flags;
                out_mode <= s1_mode;
            end
        end
    end

endmodule
